// File: rtl/slot_collector.sv
// slot_collector: return-side partner of the four-slot pipeline input selector.
// Captures iteration results per slot into feedback registers, counts iterations,
// detects escape / iteration limit and drains four pixel results via valid/ready.
// Optional feature macro: SLOT_COLLECTOR_STATS_EN adds a saturating escape counter.
module slot_collector #(
    parameter int unsigned          WIDTH      = 32,
    parameter int unsigned          ITER_W     = 8,
    parameter int unsigned          MAX_ITER   = 255,
    parameter logic [WIDTH-1:0]     ESC_THRESH = 32'h0400_0000
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                start,
    input  logic                in_valid,
    input  logic [WIDTH-1:0]    in_a,
    input  logic [WIDTH-1:0]    in_b,
    input  logic [WIDTH-1:0]    in_mag,
    output logic [WIDTH-1:0]    a1,
    output logic [WIDTH-1:0]    a2,
    output logic [WIDTH-1:0]    a3,
    output logic [WIDTH-1:0]    a4,
    output logic [WIDTH-1:0]    b1,
    output logic [WIDTH-1:0]    b2,
    output logic [WIDTH-1:0]    b3,
    output logic [WIDTH-1:0]    b4,
    output logic                busy,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [1:0]          res_slot,
    output logic [ITER_W-1:0]   res_iter,
    output logic                res_escaped,
    output logic                batch_done
`ifdef SLOT_COLLECTOR_STATS_EN
    ,
    output logic [15:0]         esc_count
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_t;

    state_t             state;
    logic [WIDTH-1:0]   fb_a [4];
    logic [WIDTH-1:0]   fb_b [4];
    logic [ITER_W-1:0]  iter [4];
    logic [3:0]         done;
    logic [3:0]         escaped;
    logic [1:0]         ptr;
    logic [1:0]         didx;

    logic [ITER_W-1:0]  iter_inc;
    logic               esc_hit;
    logic               lim_hit;
    logic [3:0]         done_set;
    logic [1:0]         didx_inc;

    assign a1 = fb_a[0];
    assign a2 = fb_a[1];
    assign a3 = fb_a[2];
    assign a4 = fb_a[3];
    assign b1 = fb_b[0];
    assign b2 = fb_b[1];
    assign b3 = fb_b[2];
    assign b4 = fb_b[3];

    // Decode of the current slot's completion conditions and drain index step.
    always_comb begin
        iter_inc = iter[ptr] + ITER_W'(1);
        esc_hit  = in_mag > ESC_THRESH;
        lim_hit  = iter_inc == ITER_W'(MAX_ITER);
        done_set = done | (4'b0001 << ptr);
        didx_inc = didx + 2'd1;
    end

    // Batch FSM with per-slot capture, counting and registered result outputs.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= StIdle;
            for (int i = 0; i < 4; i++) begin
                fb_a[i] <= '0;
                fb_b[i] <= '0;
                iter[i] <= '0;
            end
            done        <= '0;
            escaped     <= '0;
            ptr         <= '0;
            didx        <= '0;
            busy        <= 1'b0;
            res_valid   <= 1'b0;
            res_slot    <= '0;
            res_iter    <= '0;
            res_escaped <= 1'b0;
            batch_done  <= 1'b0;
        end else begin
            batch_done <= 1'b0;
            unique case (state)
                StIdle: begin
                    // Feedback registers deliberately keep their last values here.
                    if (start) begin
                        state <= StRun;
                        busy  <= 1'b1;
                        for (int i = 0; i < 4; i++) iter[i] <= '0;
                        done    <= '0;
                        escaped <= '0;
                        ptr     <= '0;
                        didx    <= '0;
                    end
                end
                StRun: begin
                    if (in_valid) begin
                        // The pointer tracks the pipeline position, so it moves even
                        // for slots that are already finished.
                        ptr <= ptr + 2'd1;
                        if (!done[ptr]) begin
                            fb_a[ptr] <= in_a;
                            fb_b[ptr] <= in_b;
                            if (iter[ptr] != ITER_W'(MAX_ITER)) iter[ptr] <= iter_inc;
                            if (esc_hit) begin
                                done[ptr]    <= 1'b1;
                                escaped[ptr] <= 1'b1;
                            end else if (lim_hit) begin
                                done[ptr]    <= 1'b1;
                            end
                            if ((esc_hit || lim_hit) && (done_set == 4'hF)) state <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (!res_valid) begin
                        // First cycle in DRAIN: present slot 0.
                        res_valid   <= 1'b1;
                        res_slot    <= didx;
                        res_iter    <= iter[didx];
                        res_escaped <= escaped[didx];
                    end else if (res_ready) begin
                        if (didx == 2'd3) begin
                            state       <= StIdle;
                            busy        <= 1'b0;
                            res_valid   <= 1'b0;
                            res_slot    <= '0;
                            res_iter    <= '0;
                            res_escaped <= 1'b0;
                            batch_done  <= 1'b1;
                            didx        <= '0;
                        end else begin
                            didx        <= didx_inc;
                            res_slot    <= didx_inc;
                            res_iter    <= iter[didx_inc];
                            res_escaped <= escaped[didx_inc];
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef SLOT_COLLECTOR_STATS_EN
    // Saturating count of accepted escaped results; only reset clears it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            esc_count <= '0;
        end else if (state == StDrain && res_valid && res_ready && res_escaped &&
                     esc_count != 16'hFFFF) begin
            esc_count <= esc_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_slot_collector.sv
// Self-checking bench for slot_collector (MAX_ITER = 8). Expected drain results are
// pushed to a queue as each batch is driven and popped as the DUT hands them out.
module tb_slot_collector;

    localparam int unsigned MAX_ITER = 8;
    localparam logic [31:0] THRESH   = 32'h0400_0000;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_a = '0, in_b = '0, in_mag = '0;
    logic        res_ready = 1'b0;
    logic [31:0] a1, a2, a3, a4, b1, b2, b3, b4;
    logic        busy, res_valid, res_escaped, batch_done;
    logic [1:0]  res_slot;
    logic [7:0]  res_iter;
`ifdef SLOT_COLLECTOR_STATS_EN
    logic [15:0] esc_count;
`endif

    typedef struct packed {
        logic [1:0] slot;
        logic [7:0] iter;
        logic       esc;
    } res_t;

    res_t        exp_q[$];
    logic [31:0] exp_a [4];
    logic [31:0] exp_b [4];
    logic [31:0] a_out [4];
    logic [31:0] b_out [4];
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 aclk = ~aclk;

    always_comb begin
        a_out[0] = a1; a_out[1] = a2; a_out[2] = a3; a_out[3] = a4;
        b_out[0] = b1; b_out[1] = b2; b_out[2] = b3; b_out[3] = b4;
    end

    slot_collector #(
        .WIDTH      (32),
        .ITER_W     (8),
        .MAX_ITER   (MAX_ITER),
        .ESC_THRESH (THRESH)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .start       (start),
        .in_valid    (in_valid),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_mag      (in_mag),
        .a1          (a1),
        .a2          (a2),
        .a3          (a3),
        .a4          (a4),
        .b1          (b1),
        .b2          (b2),
        .b3          (b3),
        .b4          (b4),
        .busy        (busy),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_slot    (res_slot),
        .res_iter    (res_iter),
        .res_escaped (res_escaped),
        .batch_done  (batch_done)
`ifdef SLOT_COLLECTOR_STATS_EN
        ,
        .esc_count   (esc_count)
`endif
    );

    function automatic logic [31:0] a_val(int s, int k);
        return 32'hA000_0000 | 32'(s << 8) | 32'(k);
    endfunction

    function automatic logic [31:0] b_val(int s, int k);
        return 32'hB000_0000 | 32'(s << 8) | 32'(k);
    endfunction

    // Start a batch and stream 32 samples; slot s gets magnitude m[s] on sample esc_at.
    task automatic feed_batch(input logic [31:0] m0, input logic [31:0] m1,
                              input logic [31:0] m2, input logic [31:0] m3,
                              input int esc_at);
        logic [31:0] mags [4];
        res_t        r;
        int          it;
        logic        esc;
        mags[0] = m0; mags[1] = m1; mags[2] = m2; mags[3] = m3;
        start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL busy_after_start got %b want 1", busy);
        else n_pass++;
        for (int s = 0; s < 4; s++) begin
            esc    = mags[s] > THRESH;
            it     = esc ? esc_at : int'(MAX_ITER);
            r.slot = 2'(s);
            r.iter = 8'(it);
            r.esc  = esc;
            exp_q.push_back(r);
            exp_a[s] = a_val(s, it - 1);
            exp_b[s] = b_val(s, it - 1);
        end
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1;
            in_a     = a_val(i % 4, i / 4);
            in_b     = b_val(i % 4, i / 4);
            in_mag   = (i / 4 == esc_at - 1) ? mags[i % 4] : 32'h0;
            @(posedge aclk); #1;
        end
        in_valid = 1'b0;
        in_mag   = '0;
        for (int s = 0; s < 4; s++) begin
            n_checks++;
            if (a_out[s] !== exp_a[s] || b_out[s] !== exp_b[s])
                $display("FAIL feedback_slot%0d got a=%h b=%h want a=%h b=%h",
                         s, a_out[s], b_out[s], exp_a[s], exp_b[s]);
            else n_pass++;
        end
    endtask

    // Drain four results against the queue, optionally stalling and poking start.
    task automatic drain(input int stall, input bit poke_start);
        int   w;
        res_t e;
        w = 0;
        while (res_valid !== 1'b1 && w < 20) begin
            @(posedge aclk); #1;
            w++;
        end
        n_checks++;
        if (res_valid !== 1'b1) begin
            $display("FAIL drain_wait got res_valid=%b want 1 within 20 cycles", res_valid);
            exp_q.delete();
            return;
        end
        n_pass++;
        for (int c = 0; c < stall; c++) begin
            if (poke_start && c == 1) start = 1'b1;
            @(posedge aclk); #1;
            start = 1'b0;
            e = exp_q[0];
            n_checks++;
            if (res_valid !== 1'b1 || res_slot !== e.slot || res_iter !== e.iter ||
                res_escaped !== e.esc || busy !== 1'b1)
                $display("FAIL stall_hold got v=%b slot=%0d iter=%0d esc=%b busy=%b want v=1 slot=%0d iter=%0d esc=%b busy=1",
                         res_valid, res_slot, res_iter, res_escaped, busy, e.slot, e.iter, e.esc);
            else n_pass++;
        end
        res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (res_valid !== 1'b1 || res_slot !== e.slot || res_iter !== e.iter ||
                res_escaped !== e.esc)
                $display("FAIL result_%0d got v=%b slot=%0d iter=%0d esc=%b want v=1 slot=%0d iter=%0d esc=%b",
                         k, res_valid, res_slot, res_iter, res_escaped, e.slot, e.iter, e.esc);
            else n_pass++;
            @(posedge aclk); #1;
        end
        res_ready = 1'b0;
        n_checks++;
        if (batch_done !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0)
            $display("FAIL batch_done_pulse got done=%b busy=%b v=%b want done=1 busy=0 v=0",
                     batch_done, busy, res_valid);
        else n_pass++;
    endtask

    task automatic check_done_low();
        @(posedge aclk); #1;
        n_checks++;
        if (batch_done !== 1'b0 || busy !== 1'b0)
            $display("FAIL batch_done_single got done=%b busy=%b want done=0 busy=0",
                     batch_done, busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if ({a1, a2, a3, a4, b1, b2, b3, b4, busy, res_valid, res_slot, res_iter,
             res_escaped, batch_done} !== '0)
            $display("FAIL reset_values got busy=%b v=%b a1=%h want all zero", busy, res_valid, a1);
        else n_pass++;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        // Ten samples: iter[0] = 3, ptr = 2.
        start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_a     = a_val(i % 4, i / 4);
            in_b     = b_val(i % 4, i / 4);
            @(posedge aclk); #1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (a1 !== a_val(0, 2) || busy !== 1'b1)
            $display("FAIL pre_reset_run got a1=%h busy=%b want a1=%h busy=1", a1, busy, a_val(0, 2));
        else n_pass++;
        #2 aresetn = 1'b0;
        #1;
        n_checks++;
        if ({a1, a2, a3, a4, b1, b2, b3, b4, busy, res_valid, res_slot, res_iter,
             res_escaped, batch_done} !== '0)
            $display("FAIL async_reset got busy=%b a1=%h b3=%h want all zero", busy, a1, b3);
        else n_pass++;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge aclk); #1;
            n_checks++;
            if (batch_done !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0)
                $display("FAIL post_reset_idle got done=%b busy=%b v=%b want 0 0 0",
                         batch_done, busy, res_valid);
            else n_pass++;
        end
    endtask

    task automatic test_no_escape();
        feed_batch(32'h0, 32'h0, 32'h0, 32'h0, 1);
        // Last sample's edge entered DRAIN; res_valid follows one cycle later.
        n_checks++;
        if (res_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL drain_entry got v=%b busy=%b want v=0 busy=1", res_valid, busy);
        else n_pass++;
        @(posedge aclk); #1;
        n_checks++;
        if (res_valid !== 1'b1)
            $display("FAIL res_valid_latency got %b want 1", res_valid);
        else n_pass++;
        drain(0, 1'b0);
        check_done_low();
    endtask

    task automatic test_early_escape();
        feed_batch(32'h0, THRESH + 32'd1, 32'h0, 32'h0, 3);
        drain(0, 1'b0);
        check_done_low();
    endtask

    task automatic test_threshold();
        feed_batch(THRESH, 32'h0, THRESH + 32'd1, 32'h0, 2);
        drain(0, 1'b0);
        check_done_low();
    endtask

    task automatic test_backpressure();
        feed_batch(32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 5);
        drain(5, 1'b0);
        check_done_low();
    endtask

    task automatic test_back_to_back();
        feed_batch(32'h0, 32'h0, THRESH + 32'd7, 32'h0, 4);
        drain(0, 1'b0);
        // Start issued in the batch_done cycle must be accepted.
        feed_batch(THRESH + 32'd1, 32'h0, 32'h0, 32'h0, 1);
        drain(0, 1'b0);
        check_done_low();
    endtask

    task automatic test_stats();
        aresetn = 1'b0;
        #2 aresetn = 1'b1;
        @(posedge aclk); #1;
        feed_batch(32'h0, THRESH + 32'd1, 32'h0, 32'h0, 3);
        drain(3, 1'b1);
        check_done_low();
        feed_batch(THRESH + 32'd1, 32'h0, THRESH + 32'd1, THRESH + 32'd1, 3);
        drain(4, 1'b1);
        check_done_low();
`ifdef SLOT_COLLECTOR_STATS_EN
        n_checks++;
        if (esc_count !== 16'd4)
            $display("FAIL esc_count got %0d want 4", esc_count);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_no_escape();
        test_early_escape();
        test_threshold();
        test_backpressure();
        test_back_to_back();
        test_stats();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
